// File: rtl/spi_mem_if.sv
// spi_mem_if: serial pin bundle between an off-chip host
// and spi_mem_target.
interface spi_mem_if;
  logic cs_n;
  logic din;
  logic dout;
  logic dout_oe;
  logic wr_done;
  logic rd_done;
  logic abort;

  modport master (
    output cs_n, din,
    input  dout, dout_oe, wr_done, rd_done, abort
  );

  modport slave (
    input  cs_n, din,
    output dout, dout_oe, wr_done, rd_done, abort
  );
endinterface

// File: rtl/spi_mem_target.sv
// spi_mem_target: chip-select framed serial port onto a
// 2**ADDR_W x DATA_W synchronous RAM with burst auto-increment.
module spi_mem_target #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int TURN   = 2
) (
  input logic      clk,
  input logic      rst_n,
  spi_mem_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int M1 = (ADDR_W > TURN) ? ADDR_W : TURN;
  localparam int MC = (DATA_W > M1) ? DATA_W : M1;
  localparam int CW = $clog2(MC) + 1;

  typedef enum logic [2:0] {
    SYNC, IDLE, ADDR, CMD, TRN, WDATA, RDATA
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] addr, waddr;
  logic rw;
  logic [DATA_W-2:0] wsr;
  logic [DATA_W-1:0] wbuf, rsr, rdata;
  logic wpend, oe;
  logic wr_done_q, rd_done_q, abort_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic last_a, last_t, last_d;
  logic cap_addr, cap_rw, oe_set;
  logic rd_load, rd_shift, rd_last;
  logic wr_shift, wr_last, abort_n;

  assign last_a = cnt == CW'(ADDR_W - 1);
  assign last_t = cnt == CW'(TURN - 1);
  assign last_d = cnt == CW'(DATA_W - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (bus.cs_n) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        SYNC: begin
        end
        IDLE: begin
          if (ADDR_W == 1) begin
            state_n = CMD;
          end else begin
            state_n = ADDR;
            cnt_n   = CW'(1);
          end
        end
        ADDR: begin
          if (last_a) begin
            state_n = CMD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        CMD: begin
          state_n = TRN;
          cnt_n   = '0;
        end
        TRN: begin
          if (last_t) begin
            state_n = rw ? WDATA : RDATA;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        WDATA, RDATA: begin
          cnt_n = last_d ? '0 : cnt + CW'(1);
        end
        default: state_n = SYNC;
      endcase
    end
  end

  always_comb begin
    cap_addr = 1'b0;
    cap_rw   = 1'b0;
    oe_set   = 1'b0;
    rd_load  = 1'b0;
    rd_shift = 1'b0;
    rd_last  = 1'b0;
    wr_shift = 1'b0;
    wr_last  = 1'b0;
    abort_n  = 1'b0;
    if (bus.cs_n) begin
      // a frame may only end cleanly on a word boundary
      unique case (state)
        ADDR, CMD, TRN: abort_n = 1'b1;
        WDATA, RDATA:   abort_n = cnt != '0;
        default:        abort_n = 1'b0;
      endcase
    end else begin
      unique case (state)
        IDLE, ADDR: cap_addr = 1'b1;
        CMD:        cap_rw   = 1'b1;
        TRN: begin
          oe_set  = last_t && !rw;
          rd_load = last_t && !rw;
        end
        WDATA: begin
          wr_shift = 1'b1;
          wr_last  = last_d;
        end
        RDATA: begin
          rd_shift = !last_d;
          rd_load  = last_d;
          rd_last  = last_d;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      waddr     <= '0;
      rw        <= 1'b0;
      wsr       <= '0;
      wbuf      <= '0;
      wpend     <= 1'b0;
      rsr       <= '0;
      oe        <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      wpend     <= wr_last;
      wr_done_q <= wpend;
      rd_done_q <= rd_last;
      abort_q   <= abort_n;
      if (cap_addr)
        addr <= (addr << 1) | ADDR_W'(bus.din);
      else if (wr_last || rd_load)
        addr <= addr + ADDR_W'(1);
      if (cap_rw)
        rw <= bus.din;
      if (wr_shift)
        wsr <= {wsr[DATA_W-3:0], bus.din};
      if (wr_last) begin
        wbuf  <= {wsr, bus.din};
        waddr <= addr;
      end
      if (rd_load)
        rsr <= rdata;
      else if (rd_shift)
        rsr <= rsr << 1;
      if (bus.cs_n)
        oe <= 1'b0;
      else if (oe_set)
        oe <= 1'b1;
    end
  end

  // rdata tracks addr every cycle, so the next burst word is
  // already prefetched when the current one finishes
  always_ff @(posedge clk) begin
    if (wpend)
      mem[waddr] <= wbuf;
    rdata <= mem[addr];
  end

  assign bus.dout    = oe & rsr[DATA_W-1];
  assign bus.dout_oe = oe;
  assign bus.wr_done = wr_done_q;
  assign bus.rd_done = rd_done_q;
  assign bus.abort   = abort_q;
endmodule

// File: tb/tb_spi_mem_target.sv
// tb_spi_mem_target: directed and random frames checked
// edge by edge against an array model of the RAM.
module tb_spi_mem_target;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int TW = 2;
  localparam int H  = AW + 1 + TW;
  localparam int D  = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miss = 0;
  logic [DW-1:0] model [D];
  logic [DW-1:0] wq [64];

  spi_mem_if bus();

  spi_mem_target #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TURN(TW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One frame: cs_n low for edges 0..L-1, high at edge L.
  task automatic frame(input int a, input bit wr,
                       input int L);
    logic [DW-1:0] snap [D];
    int s, nfull;
    logic eo, ed, ew, er, ea;
    snap = model;
    for (int e = 0; e <= L; e++) begin
      @(negedge clk);
      bus.cs_n = (e >= L);
      if (e < AW)
        bus.din = a[AW-1-e];
      else if (e == AW)
        bus.din = wr;
      else if (wr && e >= H && e < L)
        bus.din = wq[(e-H)/DW][DW-1-((e-H)%DW)];
      else
        bus.din = 1'($urandom);
      @(posedge clk);
      #1;
      eo = !wr && e >= H-1 && e < L;
      ed = 1'b0;
      if (eo) begin
        s  = e - (H-1);
        ed = snap[(a + s/DW) % D][DW-1-(s%DW)];
      end
      er = !wr && e >= H && e < L && (e-H+1) % DW == 0;
      ew = wr && e >= H+DW && (e-H) % DW == 0 && e <= L;
      ea = e == L && L > 0 &&
           (L < H || (L-H) % DW != 0);
      chk($sformatf("a%0d e%0d dout_oe", a, e),
          bus.dout_oe, eo);
      chk($sformatf("a%0d e%0d dout", a, e), bus.dout, ed);
      chk($sformatf("a%0d e%0d rd_done", a, e),
          bus.rd_done, er);
      chk($sformatf("a%0d e%0d wr_done", a, e),
          bus.wr_done, ew);
      chk($sformatf("a%0d e%0d abort", a, e),
          bus.abort, ea);
    end
    nfull = (L >= H) ? (L-H)/DW : 0;
    if (wr)
      for (int k = 0; k < nfull; k++)
        model[(a+k) % D] = wq[k];
  endtask

  initial begin
    int a, L, mode;
    bit wr;
    bus.cs_n = 1'b1;
    bus.din  = 1'b0;
    #12;
    chk("rst dout", bus.dout, 0);
    chk("rst dout_oe", bus.dout_oe, 0);
    chk("rst wr_done", bus.wr_done, 0);
    chk("rst rd_done", bus.rd_done, 0);
    chk("rst abort", bus.abort, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < D; k++)
      wq[k] = DW'($urandom);
    frame(0, 1, H + D*DW);

    wq[0] = 16'hBEEF;
    frame(5, 1, H + DW);
    frame(5, 0, H + DW);
    chk("beef model", model[5], 16'hBEEF);

    wq[0] = 16'h1111;
    wq[1] = 16'h2222;
    wq[2] = 16'h3333;
    frame(30, 1, H + 3*DW);
    frame(30, 0, H + 3*DW);

    wq[0] = 16'hAAAA;
    frame(3, 1, H + DW);
    wq[0] = 16'h5555;
    frame(3, 1, H + 7);
    frame(3, 0, H + DW);

    a = $urandom_range(0, D-1);
    wq[0] = DW'($urandom);
    wq[1] = DW'($urandom);
    frame(a, 1, H + 2*DW);
    frame(a, 0, H + 2*DW);

    // asynchronous reset in the middle of read data
    a = 9;
    for (int e = 0; e < H + 5; e++) begin
      @(negedge clk);
      bus.cs_n = 1'b0;
      bus.din  = (e < AW) ? a[AW-1-e] : 1'b0;
      @(posedge clk);
    end
    #1;
    chk("pre-rst dout_oe", bus.dout_oe, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst dout", bus.dout, 0);
    chk("arst dout_oe", bus.dout_oe, 0);
    chk("arst rd_done", bus.rd_done, 0);
    chk("arst wr_done", bus.wr_done, 0);
    chk("arst abort", bus.abort, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.cs_n = 1'b0;
      bus.din  = ~bus.din;
      @(posedge clk);
      #1;
      chk($sformatf("sync%0d dout_oe", i), bus.dout_oe, 0);
      chk($sformatf("sync%0d wr_done", i), bus.wr_done, 0);
      chk($sformatf("sync%0d abort", i), bus.abort, 0);
    end
    @(negedge clk);
    bus.cs_n = 1'b1;
    @(posedge clk);
    #1;
    chk("sync end abort", bus.abort, 0);
    frame(a, 0, H + DW);

    a = $urandom_range(0, D-1);
    frame(a, 1, 3);
    frame(a, 0, 3);
    frame(a, 0, H + DW);

    for (int n = 0; n < 30; n++) begin
      a    = $urandom_range(0, D-1);
      wr   = 1'($urandom);
      mode = $urandom_range(0, 2);
      for (int k = 0; k < 4; k++)
        wq[k] = DW'($urandom);
      if (mode == 0)
        L = H + DW * $urandom_range(1, 3);
      else if (mode == 1)
        L = $urandom_range(1, H);
      else
        L = H + $urandom_range(1, 3*DW - 1);
      frame(a, wr, L);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miss);
    $finish;
  end
endmodule
